// File: rtl/wptr_full_lvl_if.sv
// Write-side bus of the async FIFO write-pointer controller.
// The master is the write agent; the slave is wptr_full_lvl.
interface wptr_full_lvl_if #(
    parameter int ADDR_WIDTH = 7
);
    logic                  winc;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic                  wovf_clr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  wfull;
    logic                  wafull;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  woverflow;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  waddr, wptr, wfull, wafull, wlevel, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output waddr, wptr, wfull, wafull, wlevel, woverflow
    );
endinterface

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer/flag controller for the async FIFO.
// Keeps binary and Gray write pointers, derives registered full, almost-full,
// fill level and a sticky overflow flag from the synchronised Gray read pointer.
module wptr_full_lvl #(
    parameter int ADDR_WIDTH  = 7,
    parameter int AFULL_LEVEL = 2**ADDR_WIDTH - 2
) (
    input logic             wclk,
    input logic             wrst_n,
    wptr_full_lvl_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AFULL_L = AFULL_LEVEL[AW:0];

    logic [AW:0] wbin;
    logic [AW:0] wgray;
    logic [AW:0] wlevel;
    logic        wfull;
    logic        wafull;
    logic        woverflow;

    logic        wen;
    logic [AW:0] wbin_nxt;
    logic [AW:0] wgray_nxt;
    logic [AW:0] rbin;
    logic [AW:0] lvl_nxt;
    logic [AW:0] full_cmp;
    logic        ovf_set;

    // Next-pointer, read-pointer decode and level arithmetic, all from the same lvl_nxt
    always_comb begin
        wen       = bus.winc & ~wfull;
        wbin_nxt  = wbin + {{AW{1'b0}}, wen};
        wgray_nxt = (wbin_nxt >> 1) ^ wbin_nxt;
        rbin      = '0;
        // Gray-to-binary: bit i is the XOR of all Gray bits at or above i
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(bus.wq2_rptr >> i);
        end
        lvl_nxt   = wbin_nxt - rbin;
        // Full when the write pointer is one lap ahead: top two Gray bits inverted
        full_cmp  = {~bus.wq2_rptr[AW:AW-1], bus.wq2_rptr[AW-2:0]};
        ovf_set   = bus.winc & wfull;
    end

    // Pointer and flag registers
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wgray  <= '0;
            wlevel <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
        end else begin
            wbin   <= wbin_nxt;
            wgray  <= wgray_nxt;
            wlevel <= lvl_nxt;
            wfull  <= (wgray_nxt == full_cmp);
            wafull <= (lvl_nxt >= AFULL_L);
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n)           woverflow <= 1'b0;
        else if (ovf_set)      woverflow <= 1'b1;
        else if (bus.wovf_clr) woverflow <= 1'b0;
    end

    assign bus.waddr     = wbin[AW-1:0];
    assign bus.wptr      = wgray;
    assign bus.wfull     = wfull;
    assign bus.wafull    = wafull;
    assign bus.wlevel    = wlevel;
    assign bus.woverflow = woverflow;
endmodule

// File: tb/tb_wptr_full_lvl.sv
// Self-checking bench for wptr_full_lvl (ADDR_WIDTH=3, DEPTH=8, AFULL_LEVEL=6).
// Model: unbounded write/read counts; level is their difference.
module tb_wptr_full_lvl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;

    logic wclk = 1'b0;
    logic wrst_n = 1'b0;

    wptr_full_lvl_if #(.ADDR_WIDTH(AW)) bus ();

    wptr_full_lvl #(.ADDR_WIDTH(AW), .AFULL_LEVEL(AFL)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus.slave)
    );

    always #5 wclk = ~wclk;

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    // model state
    int   m_wcnt = 0;
    int   m_rd   = 0;
    int   m_level = 0;
    logic m_full = 1'b0;
    logic m_afull = 1'b0;
    logic m_ovf = 1'b0;

    function automatic logic [3:0] gray(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wcnt = 0; m_rd = 0; m_level = 0;
        m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    endtask

    // One write-clock cycle: drive inputs after the falling edge, update the model at the rising edge
    task automatic cycle(input logic w, input int rd, input logic clr);
        logic old_full;
        @(negedge wclk);
        #1;
        bus.winc     = w;
        bus.wq2_rptr = gray(rd);
        bus.wovf_clr = clr;
        @(posedge wclk);
        old_full = m_full;
        if (w && !m_full) m_wcnt++;
        m_rd    = rd;
        m_level = m_wcnt - rd;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= AFL);
        if (w && old_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_waddr"},  int'(bus.waddr), 0);
        chk({tag, "_wptr"},   int'(bus.wptr), 0);
        chk({tag, "_wlevel"}, int'(bus.wlevel), 0);
        chk({tag, "_wfull"},  int'(bus.wfull), 0);
        chk({tag, "_wafull"}, int'(bus.wafull), 0);
        chk({tag, "_wovf"},   int'(bus.woverflow), 0);
    endtask

    // Per-cycle compare of every output against the model
    always @(negedge wclk) begin
        if (check_en && wrst_n) begin
            chk("waddr",     int'(bus.waddr),     m_wcnt % DEPTH);
            chk("wptr",      int'(bus.wptr),      int'(gray(m_wcnt)));
            chk("wlevel",    int'(bus.wlevel),    m_level);
            chk("wfull",     int'(bus.wfull),     int'(m_full));
            chk("wafull",    int'(bus.wafull),    int'(m_afull));
            chk("woverflow", int'(bus.woverflow), int'(m_ovf));
        end
    end

    initial begin
        int rd;
        bit seen_1000;
        bus.winc = 1'b0; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;

        // 1 reset with garbage inputs
        for (int i = 0; i < 4; i++) begin
            @(negedge wclk);
            bus.winc     = 1'($urandom);
            bus.wq2_rptr = 4'($urandom);
            bus.wovf_clr = 1'($urandom);
        end
        #1;
        chk_zero("rst");
        @(negedge wclk);
        bus.winc = 1'b0; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;
        #2 wrst_n = 1'b1;
        model_reset();
        check_en = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0);
        chk_zero("idle");

        // 2 fill
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 0, 1'b0);
            chk("fill_lvl", int'(bus.wlevel), i + 1);
            chk("fill_afull", int'(bus.wafull), (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill_wptr", int'(bus.wptr), 12);
        chk("fill_full", int'(bus.wfull), 1);

        // 3 overflow
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 0, 1'b0);
        chk("ovf_wptr", int'(bus.wptr), 12);
        chk("ovf_set", int'(bus.woverflow), 1);
        cycle(1'b0, 0, 1'b1);
        chk("ovf_clr", int'(bus.woverflow), 0);
        cycle(1'b1, 0, 1'b0);
        cycle(1'b1, 0, 1'b1);
        chk("ovf_setwins", int'(bus.woverflow), 1);
        cycle(1'b0, 0, 1'b1);

        // 4 drain: read pointer jumps to 3
        cycle(1'b0, 3, 1'b0);
        chk("drain_full", int'(bus.wfull), 0);
        chk("drain_lvl", int'(bus.wlevel), 5);
        chk("drain_afull", int'(bus.wafull), 0);

        // 5 wrap with read pointer trailing
        seen_1000 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, m_wcnt - 1, 1'b0);
            chk("wrap_lvl", int'(bus.wlevel), 2);
            if (bus.wptr == 4'b1000) seen_1000 = 1'b1;
        end
        chk("wrap_full", int'(bus.wfull), 0);
        chk("wrap_seen1000", int'(seen_1000), 1);

        // random traffic
        rd = m_rd;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) rd = rd + $urandom_range(0, m_wcnt - rd);
            cycle(1'($urandom_range(0, 3) != 0), rd, 1'($urandom_range(0, 7) == 0));
        end

        // 6 async reset mid-fill at level 5 with a write in flight
        rd = m_wcnt;
        for (int i = 0; i < 12 && m_level < 5; i++) cycle(1'b1, rd, 1'b0);
        chk("pre_rst_lvl", int'(bus.wlevel), 5);
        @(negedge wclk);
        #1 bus.winc = 1'b1;
        #1 check_en = 1'b0;
        wrst_n = 1'b0;
        #1;
        chk_zero("async");
        bus.wq2_rptr = 4'($urandom);
        @(posedge wclk);
        @(negedge wclk);
        bus.winc = 1'b0; bus.wq2_rptr = '0; bus.wovf_clr = 1'b0;
        #2 wrst_n = 1'b1;
        model_reset();
        check_en = 1'b1;
        cycle(1'b1, 0, 1'b0);
        chk("post_waddr", int'(bus.waddr), 1);
        chk("post_lvl", int'(bus.wlevel), 1);
        cycle(1'b0, 0, 1'b0);

        @(negedge wclk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
